// File: rtl/noc_router_pkg.sv
// Shared definitions for the mesh NoC router: flit types, output port
// indices and small field helpers.
package noc_router_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'b00,
        FLIT_BODY      = 2'b01,
        FLIT_TAIL      = 2'b10,
        FLIT_HEAD_TAIL = 2'b11
    } flit_type_e;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_N = 3'd0;
    localparam logic [2:0] PORT_S = 3'd1;
    localparam logic [2:0] PORT_W = 3'd2;
    localparam logic [2:0] PORT_E = 3'd3;
    localparam logic [2:0] PORT_L = 3'd4;

    function automatic flit_type_e flit_type_f(input logic [1:0] type_bits);
        return flit_type_e'(type_bits);
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot_f(input logic [2:0] idx);
        logic [NUM_PORTS-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/xy_route_calc.sv
// Dimension-ordered (X first, then Y) route computation for one flit.
module xy_route_calc
    import noc_router_pkg::*;
#(
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0
) (
    input  logic [X_W-1:0]       x_dest_i,
    input  logic [Y_W-1:0]       y_dest_i,
    output logic [NUM_PORTS-1:0] route_o
);

    localparam logic [X_W-1:0] RX = X_W'(ROUTER_X);
    localparam logic [Y_W-1:0] RY = Y_W'(ROUTER_Y);

    always_comb begin
        if (x_dest_i > RX) begin
            route_o = port_onehot_f(PORT_E);
        end else if (x_dest_i < RX) begin
            route_o = port_onehot_f(PORT_W);
        end else if (y_dest_i > RY) begin
            route_o = port_onehot_f(PORT_N);
        end else if (y_dest_i < RY) begin
            route_o = port_onehot_f(PORT_S);
        end else begin
            route_o = port_onehot_f(PORT_L);
        end
    end

endmodule

// File: rtl/input_router_xy.sv
// Per-input routing stage: XY route on head flits, per-VC route table for
// body/tail flits, registered valid/ready output with error and drop count.
module input_router_xy
    import noc_router_pkg::*;
#(
    parameter int FLIT_W   = 34,
    parameter int NUM_VC   = 2,
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic [FLIT_W-1:0]    flit_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [FLIT_W-1:0]    flit_o,
    output logic [NUM_PORTS-1:0] route_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 err_o,
    output logic [CNT_W-1:0]     drop_cnt_o
);

    localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam logic [VC_W:0] NUM_VC_L = (VC_W+1)'(NUM_VC);

    logic [FLIT_W-1:0]    flit_q, flit_d;
    logic [NUM_PORTS-1:0] route_q, route_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_VC-1:0]    open_q, open_d;
    logic [NUM_PORTS-1:0] table_q [NUM_VC];
    logic [NUM_PORTS-1:0] table_d [NUM_VC];

    flit_type_e           ftype;
    logic [X_W-1:0]       x_dest;
    logic [Y_W-1:0]       y_dest;
    logic [VC_W-1:0]      vc_raw;
    logic [VC_W-1:0]      vc_idx;
    logic                 vc_bad;
    logic                 accept;
    logic                 drop;
    logic [NUM_PORTS-1:0] route_xy;

    assign ftype  = flit_type_f(flit_i[FLIT_W-1 -: 2]);
    assign x_dest = flit_i[FLIT_W-3 -: X_W];
    assign y_dest = flit_i[FLIT_W-3-X_W -: Y_W];
    assign vc_raw = flit_i[VC_W-1:0];

    // A single-VC router ignores the vc field entirely.
    assign vc_bad = (NUM_VC > 1) && ({1'b0, vc_raw} >= NUM_VC_L);
    assign vc_idx = ((NUM_VC == 1) || vc_bad) ? '0 : vc_raw;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    xy_route_calc #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .ROUTER_X (ROUTER_X),
        .ROUTER_Y (ROUTER_Y)
    ) u_xy_route_calc (
        .x_dest_i (x_dest),
        .y_dest_i (y_dest),
        .route_o  (route_xy)
    );

    always_comb begin
        flit_d  = flit_q;
        route_d = route_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        open_d  = open_q;
        table_d = table_q;
        drop    = 1'b0;

        if (ready_o) begin
            valid_d = 1'b0;
            route_d = '0;
        end

        if (accept) begin
            if (vc_bad) begin
                drop = 1'b1;
            end else begin
                case (ftype)
                    FLIT_HEAD: begin
                        flit_d          = flit_i;
                        route_d         = route_xy;
                        valid_d         = 1'b1;
                        table_d[vc_idx] = route_xy;
                        open_d[vc_idx]  = 1'b1;
                        err_d           = open_q[vc_idx];
                    end
                    FLIT_HEAD_TAIL: begin
                        flit_d         = flit_i;
                        route_d        = route_xy;
                        valid_d        = 1'b1;
                        open_d[vc_idx] = 1'b0;
                    end
                    FLIT_BODY: begin
                        if (open_q[vc_idx]) begin
                            flit_d  = flit_i;
                            route_d = table_q[vc_idx];
                            valid_d = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    default: begin
                        if (open_q[vc_idx]) begin
                            flit_d         = flit_i;
                            route_d        = table_q[vc_idx];
                            valid_d        = 1'b1;
                            open_d[vc_idx] = 1'b0;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                endcase
            end

            if (drop) begin
                err_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            flit_q  <= '0;
            route_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            open_q  <= '0;
            table_q <= '{default: '0};
        end else begin
            flit_q  <= flit_d;
            route_q <= route_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            table_q <= table_d;
        end
    end

    assign flit_o     = flit_q;
    assign route_o    = route_q;
    assign valid_o    = valid_q;
    assign err_o      = err_q;
    assign drop_cnt_o = cnt_q;

endmodule

// File: doc/input_router_xy.md
Name: input_router_xy

Overview:
Parametrised successor to the per-input routing stage of the mesh NoC router. Sits between the input buffer of one router port and the switch allocator. On a head flit it computes a dimension-ordered (XY) route and records it in a per-VC routing table; body and tail flits of the same packet reuse the stored route. Output is registered: one flit per cycle with a valid/ready handshake on both sides, a one-hot output-port request, error flagging and a drop counter.

Parameters:
FLIT_W, 34, total flit width in bits
NUM_VC, 2, number of virtual channels; VC_W = max(1, clog2(NUM_VC))
X_W, 2, width of the X destination field
Y_W, 2, width of the Y destination field
ROUTER_X, 0, X coordinate of this router (unsigned)
ROUTER_Y, 0, Y coordinate of this router (unsigned)
CNT_W, 8, width of the drop counter

Ports:
clk  in  1  clock; all state updates on rising edge
arst  in  1  reset, synchronous, active-high
flit_i  in  FLIT_W  input flit
valid_i  in  1  input flit valid
ready_o  out  1  input ready; a flit is accepted when valid_i && ready_o
flit_o  out  FLIT_W  registered flit to switch allocator
route_o  out  NUM_PORTS  one-hot port request: [0]N [1]S [2]W [3]E [4]Local
valid_o  out  1  output valid
ready_i  in  1  downstream ready
err_o  out  1  one-cycle pulse on a protocol error
drop_cnt_o  out  CNT_W  saturating count of dropped flits

Behaviour:
- Flit fields: type = flit_i[FLIT_W-1:FLIT_W-2] (00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL); x_dest = next X_W bits down; y_dest = next Y_W bits below that; vc = flit_i[VC_W-1:0] (treated as 0 when NUM_VC=1); vc >= NUM_VC is taken modulo-free as an error (drop, err_o).
- Reset (arst=1 at a clock edge): valid_o=0, flit_o=0, route_o=0, err_o=0, drop_cnt_o=0, all table entries 0, all open[vc]=0. Reset mid-packet discards all packet state; the next flit on any VC must be a head.
- ready_o = !valid_o || ready_i (combinational). Latency: an accepted flit appears on flit_o/route_o at the next edge.
- Output register holds flit_o/route_o/valid_o stable while valid_o && !ready_i.
- XY route, unsigned compare: x_dest>ROUTER_X -> E; x_dest<ROUTER_X -> W; else y_dest>ROUTER_Y -> N; y_dest<ROUTER_Y -> S; else Local.
- HEAD accepted: route = XY(flit); table[vc] <= route; open[vc] <= 1. If open[vc] was already 1: still forward, overwrite the route, and pulse err_o (unterminated packet).
- HEAD_TAIL accepted: route = XY(flit), forwarded; open[vc] <= 0; table not written.
- BODY accepted with open[vc]=1: forwarded with route = table[vc].
- TAIL accepted with open[vc]=1: forwarded with route = table[vc]; open[vc] <= 0.
- BODY/TAIL accepted with open[vc]=0: dropped (accepted, not forwarded; valid_o is 0 next cycle unless still holding); err_o pulses; drop_cnt_o += 1, saturating at 2^CNT_W-1.
- err_o is high for exactly the cycle after the offending acceptance; otherwise 0.
- Interleaving across VCs is legal; the state of each VC is independent.
- Each valid forwarded flit carries exactly one route_o bit set; route_o = 0 whenever valid_o = 0.

Decomposition:
- Shared package noc_router_pkg: flit type enum (HEAD, BODY, TAIL, HEAD_TAIL), port index constants (PORT_N..PORT_L), NUM_PORTS=5, field-extract helper functions.
- One sub-module: xy_route_calc (combinational, coordinates in, one-hot route out). The table, open bits, output register and counter stay in the top level.

Test Plan:
- ROUTER=(1,1), HEAD vc0 dest(3,0), BODY, TAIL, ready_i=1 -> three consecutive valid_o cycles, route_o=5'b01000 (E) each, err_o=0, open[0]=0 at the end.
- HEAD_TAIL dest(1,1) -> route_o=5'b10000 (Local) after 1 cycle; a following BODY on vc0 -> dropped, err_o pulse, drop_cnt_o=1.
- Interleave vc0 HEAD dest(0,1) (W) and vc1 HEAD dest(1,3) (N), then alternate their BODYs -> each body carries its own VC's route (00100 / 00001).
- ready_i=0 for 3 cycles with valid_o=1 -> ready_o=0, flit_o/route_o stable; a new flit is accepted on the cycle ready_i returns to 1.
- Two HEADs on vc0 with no TAIL -> second is forwarded with the new route, err_o pulses once, drop_cnt_o is unchanged.
- CNT_W=2, 5 orphan BODYs -> drop_cnt_o saturates at 3; assert arst mid-packet -> all outputs 0 and a later BODY is dropped.
